// File: rtl/station_pkg.sv
// Shared state codes, operator-panel event codes and sizing helpers for the
// station dispatcher. Optional emergency stop is enabled by the macro
// STATION_DISPATCH_ESTOP_EN.
package station_pkg;

  // Platform sequencing states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARRIVE = 3'd1;
  localparam logic [2:0] ST_OPEN   = 3'd2;
  localparam logic [2:0] ST_DWELL  = 3'd3;
  localparam logic [2:0] ST_CLOSE  = 3'd4;
  localparam logic [2:0] ST_DEPART = 3'd5;

  // Operator panel event codes
  localparam logic [3:0] EV_GOTOWORK    = 4'b0000;
  localparam logic [3:0] EV_STOPWORK    = 4'b0001;
  localparam logic [3:0] EV_GOTOST      = 4'b0010;
  localparam logic [3:0] EV_WAIT        = 4'b0011;
  localparam logic [3:0] EV_DRSOPEN     = 4'b0100;
  localparam logic [3:0] EV_DRSCNTOPEN  = 4'b0101;
  localparam logic [3:0] EV_DRSCLOSE    = 4'b0110;
  localparam logic [3:0] EV_DRSCNTCLOSE = 4'b0111;
  localparam logic [3:0] EV_SMTHWRONG   = 4'b1000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Index width that stays at least one bit wide for a single requester
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick of the first request at or after
// the pointer (wrapping), pointer advanced past the served index on i_adv.
module rr_arbiter
  import station_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          i_req,
  input  logic                  i_adv,
  input  logic [idx_w(N)-1:0]   i_adv_idx,
  output logic [N-1:0]          o_pick_c,
  output logic [idx_w(N)-1:0]   o_pick_idx_c,
  output logic                  o_any_c
);

  localparam int unsigned IW = idx_w(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_j;

  // Priority scan starting at the pointer, wrapping modulo N
  always_comb begin
    o_pick_c     = '0;
    o_pick_idx_c = '0;
    o_any_c      = 1'b0;
    w_j          = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = IW'((32'(r_ptr) + k) % N);
      if (!o_any_c && i_req[w_j]) begin
        o_any_c      = 1'b1;
        o_pick_idx_c = w_j;
        o_pick_c     = N'(1) << w_j;
      end
    end
  end

  // Pointer moves to the slot after the train that just departed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (32'(i_adv_idx) == (N - 1)) ? '0 : i_adv_idx + IW'(1);
    end
  end

endmodule

// File: rtl/station_dispatcher.sv
// Station dispatcher: grants the shared platform round-robin and walks the
// granted train through arrive / open / dwell / close / depart, reporting
// event codes to the operator panel. Macro STATION_DISPATCH_ESTOP_EN adds an
// emergency-stop input that zeroes ctrl and freezes the sequence in place.
module station_dispatcher
  import station_pkg::*;
#(
  parameter int unsigned NUM_TRAINS = 4,
  parameter int unsigned TRAVEL_CYC = 8,
  parameter int unsigned DWELL_CYC  = 16,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TRAINS-1:0] req,
  input  logic                  drs_ok,
  input  logic                  mng,
`ifdef STATION_DISPATCH_ESTOP_EN
  input  logic                  estop,
`endif
  output logic [NUM_TRAINS-1:0] ctrl,
  output logic [NUM_TRAINS-1:0] grant,
  output logic                  busy,
  output logic [3:0]            evnt,
  output logic                  fault
);

  localparam int unsigned CW  = $clog2(max_u(TRAVEL_CYC, DWELL_CYC) + 1);
  localparam int unsigned RW  = $clog2(MAX_RETRY + 1);
  localparam int unsigned GIW = idx_w(NUM_TRAINS);

  logic [2:0]            r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [RW-1:0]         r_retry, w_retry_nxt;
  logic                  r_phase, w_phase_nxt;
  logic [NUM_TRAINS-1:0] r_grant, w_grant_nxt;
  logic [GIW-1:0]        r_gidx, w_gidx_nxt;
  logic [NUM_TRAINS-1:0] r_ctrl, w_ctrl_nxt;
  logic [3:0]            r_evnt, w_evnt_nxt;
  logic                  r_fault, w_fault_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  w_adv;
  logic [NUM_TRAINS-1:0] w_pick;
  logic [GIW-1:0]        w_pick_idx;
  logic                  w_any;

  rr_arbiter #(.N(NUM_TRAINS)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .i_req        (req),
    .i_adv        (w_adv),
    .i_adv_idx    (r_gidx),
    .o_pick_c     (w_pick),
    .o_pick_idx_c (w_pick_idx),
    .o_any_c      (w_any)
  );

  // Next-state and next-output decode; ctrl is zero unless a state drives it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_phase_nxt = r_phase;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ctrl_nxt  = '0;
    w_evnt_nxt  = r_evnt;
    w_fault_nxt = r_fault;
    w_adv       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_fault) begin
          w_evnt_nxt = EV_SMTHWRONG;
        end else if (mng && w_any) begin
          w_state_nxt = ST_ARRIVE;
          w_grant_nxt = w_pick;
          w_gidx_nxt  = w_pick_idx;
          w_ctrl_nxt  = w_pick;
          w_cnt_nxt   = CW'(TRAVEL_CYC - 1);
          w_evnt_nxt  = EV_GOTOWORK;
        end else begin
          w_evnt_nxt = EV_STOPWORK;
        end
      end
      ST_ARRIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt  = r_cnt - CW'(1);
          w_ctrl_nxt = r_grant;
          w_evnt_nxt = EV_GOTOWORK;
        end else begin
          w_state_nxt = ST_OPEN;
          w_evnt_nxt  = EV_GOTOST;
        end
      end
      ST_OPEN: begin
        if (drs_ok) begin
          w_state_nxt = ST_DWELL;
          w_cnt_nxt   = CW'(DWELL_CYC - 1);
          w_evnt_nxt  = EV_DRSOPEN;
        end else begin
          w_evnt_nxt = EV_DRSCNTOPEN;
        end
      end
      ST_DWELL: begin
        w_evnt_nxt = EV_WAIT;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_state_nxt = ST_CLOSE;
          w_retry_nxt = '0;
          w_phase_nxt = 1'b0;
          w_ctrl_nxt  = r_grant;
        end
      end
      ST_CLOSE: begin
        if (!r_phase) begin
          // Pulse cycle done; sample the sensor on the next cycle
          w_phase_nxt = 1'b1;
          w_evnt_nxt  = (r_retry == '0) ? EV_WAIT : EV_DRSCNTCLOSE;
        end else if (drs_ok) begin
          w_state_nxt = ST_DEPART;
          w_cnt_nxt   = CW'(TRAVEL_CYC - 1);
          w_ctrl_nxt  = r_grant;
          w_evnt_nxt  = EV_DRSCLOSE;
        end else begin
          w_retry_nxt = r_retry + RW'(1);
          w_evnt_nxt  = EV_DRSCNTCLOSE;
          if ((32'(r_retry) + 32'd1) < MAX_RETRY) begin
            w_phase_nxt = 1'b0;
            w_ctrl_nxt  = r_grant;
          end else begin
            w_fault_nxt = 1'b1;
            w_evnt_nxt  = EV_SMTHWRONG;
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      ST_DEPART: begin
        if (r_cnt != '0) begin
          w_cnt_nxt  = r_cnt - CW'(1);
          w_ctrl_nxt = r_grant;
          w_evnt_nxt = EV_DRSCLOSE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_adv       = 1'b1;
          w_evnt_nxt  = EV_STOPWORK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase

`ifdef STATION_DISPATCH_ESTOP_EN
    // Emergency stop holds every sequencing register and drops all ctrl
    if (estop) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_nxt = r_retry;
      w_phase_nxt = r_phase;
      w_grant_nxt = r_grant;
      w_gidx_nxt  = r_gidx;
      w_fault_nxt = r_fault;
      w_ctrl_nxt  = '0;
      w_adv       = 1'b0;
      w_evnt_nxt  = EV_SMTHWRONG;
    end
`endif

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_retry <= '0;
      r_phase <= 1'b0;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ctrl  <= '0;
      r_evnt  <= EV_STOPWORK;
      r_fault <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      r_phase <= w_phase_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_evnt  <= w_evnt_nxt;
      r_fault <= w_fault_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign ctrl  = r_ctrl;
  assign grant = r_grant;
  assign busy  = r_busy;
  assign evnt  = r_evnt;
  assign fault = r_fault;

endmodule

// File: tb/tb_station_dispatcher.sv
// Self-checking bench for station_dispatcher: directed and randomized platform
// sequences checked cycle by cycle against a phase-timed reference model.
module tb_station_dispatcher;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int D  = 16;
  localparam int MR = 3;

  localparam logic [3:0] E_GOWORK = 4'b0000;
  localparam logic [3:0] E_STOP   = 4'b0001;
  localparam logic [3:0] E_GOST   = 4'b0010;
  localparam logic [3:0] E_WAIT   = 4'b0011;
  localparam logic [3:0] E_OPEN   = 4'b0100;
  localparam logic [3:0] E_NOPEN  = 4'b0101;
  localparam logic [3:0] E_CLOSED = 4'b0110;
  localparam logic [3:0] E_NCLOSE = 4'b0111;
  localparam logic [3:0] E_WRONG  = 4'b1000;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         drs_ok;
  logic         mng;
`ifdef STATION_DISPATCH_ESTOP_EN
  logic         estop;
`endif
  logic [N-1:0] ctrl;
  logic [N-1:0] grant;
  logic         busy;
  logic [3:0]   evnt;
  logic         fault;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  station_dispatcher #(
    .NUM_TRAINS (N),
    .TRAVEL_CYC (T),
    .DWELL_CYC  (D),
    .MAX_RETRY  (MR)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .drs_ok (drs_ok),
    .mng    (mng),
`ifdef STATION_DISPATCH_ESTOP_EN
    .estop  (estop),
`endif
    .ctrl   (ctrl),
    .grant  (grant),
    .busy   (busy),
    .evnt   (evnt),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ec,
                         input logic [3:0] ee, input logic eb, input logic ef);
    chk({tag, ".grant"}, 8'(grant), 8'(eg));
    chk({tag, ".ctrl"},  8'(ctrl),  8'(ec));
    chk({tag, ".evnt"},  8'(evnt),  8'(ee));
    chk({tag, ".busy"},  8'(busy),  8'(eb));
    chk({tag, ".fault"}, 8'(fault), 8'(ef));
  endtask

  // Round-robin winner: first requester at or after the pointer, wrapping
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    mng    = 1'b0;
    drs_ok = 1'b0;
`ifdef STATION_DISPATCH_ESTOP_EN
    estop  = 1'b0;
`endif
    step();
    chk_out("reset_held", '0, '0, E_STOP, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    m_ptr = 0;
    step();
    chk_out("reset_idle", '0, '0, E_STOP, 1'b0, 1'b0);
  endtask

  // One full platform visit starting from IDLE; close_fails >= MR ends in fault
  task automatic run_seq(input logic [N-1:0] reqv, input int open_wait, input int close_fails);
    int           g;
    logic [N-1:0] oh;
    logic [3:0]   ev_c;
    bit           ok;
    g   = pick(reqv, m_ptr);
    oh  = N'(1) << g;
    req = reqv;
    mng = 1'b1;
    step();
    chk_out("arrive", oh, oh, E_GOWORK, 1'b1, 1'b0);
    req    = N'($urandom);
    mng    = 1'($urandom);
    drs_ok = 1'($urandom);
    for (int i = 1; i < T; i++) begin
      step();
      chk_out("arrive", oh, oh, E_GOWORK, 1'b1, 1'b0);
      drs_ok = 1'($urandom);
      req    = N'($urandom);
    end
    step();
    chk_out("open_entry", oh, '0, E_GOST, 1'b1, 1'b0);
    drs_ok = (open_wait == 0);
    for (int w = 1; w <= open_wait; w++) begin
      step();
      chk_out("open_wait", oh, '0, E_NOPEN, 1'b1, 1'b0);
      drs_ok = (w == open_wait);
    end
    step();
    chk_out("dwell_entry", oh, '0, E_OPEN, 1'b1, 1'b0);
    drs_ok = 1'($urandom);
    for (int i = 1; i < D; i++) begin
      step();
      chk_out("dwell", oh, '0, E_WAIT, 1'b1, 1'b0);
      drs_ok = 1'($urandom);
    end
    ok = 1'b0;
    for (int k = 0; k < MR && !ok; k++) begin
      ev_c = (k == 0) ? E_WAIT : E_NCLOSE;
      step();
      chk_out("close_pulse", oh, oh, ev_c, 1'b1, 1'b0);
      drs_ok = 1'($urandom);
      step();
      chk_out("close_sample", oh, '0, ev_c, 1'b1, 1'b0);
      ok     = (k >= close_fails);
      drs_ok = ok;
    end
    if (ok) begin
      for (int i = 0; i < T; i++) begin
        step();
        chk_out("depart", oh, oh, E_CLOSED, 1'b1, 1'b0);
        drs_ok = 1'($urandom);
      end
      step();
      chk_out("idle_after", '0, '0, E_STOP, 1'b0, 1'b0);
      m_ptr = (g + 1) % N;
    end else begin
      step();
      chk_out("fault_entry", '0, '0, E_WRONG, 1'b0, 1'b1);
    end
    req = '0;
    mng = 1'b0;
  endtask

  initial begin
    do_reset();

    // Manager disabled: requests are not granted
    req = '1;
    mng = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("mng_off", '0, '0, E_STOP, 1'b0, 1'b0);
    end
    req = '0;

    // Single request, doors confirm at once
    run_seq(4'b0010, 0, 0);

    // All trains requesting: strict rotation from pointer 0
    do_reset();
    for (int s = 0; s < 4; s++) begin
      chk("rr_order_model", 8'(pick(4'b1111, m_ptr)), 8'(s));
      run_seq(4'b1111, 0, 0);
    end

    // Randomized requests, door-open delays and recoverable close retries
    for (int s = 0; s < 6; s++) begin
      run_seq(N'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(0, MR - 1));
    end

    // Doors slow to open: twenty waiting cycles
    run_seq(4'b1000, 20, 0);

    // Reset during dwell abandons the sequence and clears the pointer
    do_reset();
    req    = 4'b0100;
    mng    = 1'b1;
    drs_ok = 1'b1;
    for (int i = 0; i < T + 1 + 5; i++) step();
    chk_out("dwell_c5", 4'b0100, '0, E_WAIT, 1'b1, 1'b0);
    reset = 1'b1;
    req   = '0;
    step();
    chk_out("mid_reset", '0, '0, E_STOP, 1'b0, 1'b0);
    reset = 1'b0;
    m_ptr = 0;
    run_seq(4'b1010, 1, 1);

`ifdef STATION_DISPATCH_ESTOP_EN
    // Emergency stop for ten cycles in the middle of arrival
    do_reset();
    req    = 4'b0001;
    mng    = 1'b1;
    drs_ok = 1'b0;
    step();
    chk_out("es_arrive", 4'b0001, 4'b0001, E_GOWORK, 1'b1, 1'b0);
    step();
    step();
    estop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("estop", 4'b0001, '0, E_WRONG, 1'b1, 1'b0);
    end
    estop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("es_resume", 4'b0001, 4'b0001, E_GOWORK, 1'b1, 1'b0);
    end
    step();
    chk_out("es_open", 4'b0001, '0, E_GOST, 1'b1, 1'b0);
`endif

    // Door never confirms closed: three pulses, sticky fault, grants blocked
    do_reset();
    run_seq(N'($urandom_range(1, 15)), 0, MR);
    req = '1;
    mng = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("fault_hold", '0, '0, E_WRONG, 1'b0, 1'b1);
    end
    do_reset();
    run_seq(4'b0100, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
